// File: rtl/ad9226_axis_packer.sv
// ad9226_axis_packer: decimates ADC eoc frames into a 2-slot buffer and streams
// each 4-channel frame as four sign-extended AXI-Stream beats.
module ad9226_axis_packer #(
  parameter int ADC_DATA_WIDTH  = 12,
  parameter int AXIS_DATA_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       eoc,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in0,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in1,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in2,
  input  logic [ADC_DATA_WIDTH-1:0]  data_in3,
  input  logic                       enable,
  input  logic [15:0]                decimation,
  output logic [AXIS_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [1:0]                 m_axis_tuser,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic                       m_axis_tlast,
  output logic                       overflow,
  output logic [15:0]                overflow_count
);
  typedef enum logic {IDLE, SEND} state_t;
  state_t state;
  logic eoc_q, wr_ptr, rd_ptr;
  logic [15:0] dec_cnt;
  logic [1:0] count, count_n, beat;
  logic [ADC_DATA_WIDTH-1:0] fifo [2][4];
  logic [ADC_DATA_WIDTH-1:0] head;
  logic eoc_rise, qual, hs, last_hs, store, drop;
  assign eoc_rise = eoc & ~eoc_q;
  assign qual     = enable & eoc_rise & (dec_cnt == 16'd0);
  assign hs       = m_axis_tvalid & m_axis_tready;
  assign last_hs  = hs & (beat == 2'd3);
  // a full buffer still accepts when its head frame retires in the same cycle
  assign store    = qual & ((count != 2'd2) | last_hs);
  assign drop     = qual & ~store;
  assign count_n  = count + {1'b0, store} - {1'b0, last_hs};
  assign head     = fifo[rd_ptr][beat];
  assign m_axis_tvalid = state == SEND;
  assign m_axis_tdata  = m_axis_tvalid ? AXIS_DATA_WIDTH'($signed(head)) : '0;
  assign m_axis_tuser  = beat;
  assign m_axis_tlast  = m_axis_tvalid & (beat == 2'd3);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state          <= IDLE;
      eoc_q          <= 1'b0;
      dec_cnt        <= '0;
      count          <= '0;
      wr_ptr         <= 1'b0;
      rd_ptr         <= 1'b0;
      beat           <= '0;
      overflow       <= 1'b0;
      overflow_count <= '0;
    end else begin
      eoc_q   <= eoc;
      dec_cnt <= !enable ? 16'd0 : !eoc_rise ? dec_cnt : (dec_cnt == 16'd0) ? decimation : dec_cnt - 16'd1;
      count   <= count_n;
      wr_ptr  <= wr_ptr ^ store;
      rd_ptr  <= rd_ptr ^ last_hs;
      beat    <= hs ? beat + 2'd1 : beat;
      state   <= (count_n != 2'd0) ? SEND : IDLE;
      if (drop) begin
        overflow <= 1'b1;
        if (overflow_count != 16'hFFFF) overflow_count <= overflow_count + 16'd1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (store) begin
      fifo[wr_ptr][0] <= data_in0;
      fifo[wr_ptr][1] <= data_in1;
      fifo[wr_ptr][2] <= data_in2;
      fifo[wr_ptr][3] <= data_in3;
    end
  end
endmodule

// File: doc/ad9226_axis_packer.md
AD9226_AXIS_PACKER -- requirements
Module: ad9226_axis_packer

Interface
REQ-001 SHALL have parameter ADC_DATA_WIDTH, default 12: width of each ADC sample input.
REQ-002 SHALL have parameter AXIS_DATA_WIDTH, default 16: width of m_axis_tdata, at least ADC_DATA_WIDTH.
REQ-003 SHALL have port clk  input  1: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port eoc  input  1: end-of-conversion strobe from the ADC interface stage.
REQ-006 SHALL have ports data_in0..data_in3  input  ADC_DATA_WIDTH each: two's-complement offset-corrected samples, channels 0-3.
REQ-007 SHALL have port enable  input  1: when high, new frames are accepted.
REQ-008 SHALL have port decimation  input  16: keep one frame per (decimation+1) eoc rising edges.
REQ-009 SHALL have port m_axis_tdata  output  AXIS_DATA_WIDTH: the sample, sign-extended.
REQ-010 SHALL have port m_axis_tuser  output  2: channel index of the current beat.
REQ-011 SHALL have port m_axis_tvalid  output  1, port m_axis_tready  input  1, and port m_axis_tlast  output  1: the AXI-Stream handshake.
REQ-012 SHALL have port overflow  output  1: sticky frame-drop flag.
REQ-013 SHALL have port overflow_count  output  16: number of dropped frames, saturating.

Function
REQ-014 SHALL detect an eoc rising edge as eoc high in the current cycle and registered eoc low in the previous cycle; a held-high eoc counts as one edge.
REQ-015 SHALL keep a decimation counter and decide each edge as follows while enable is high:
- counter 0: the edge is a qualifying edge and the counter reloads with decimation;
- counter non-zero: the counter decrements and the edge is ignored.
REQ-016 SHALL, while enable is low, ignore all edges and hold the decimation counter at 0, so the first edge after enable rises qualifies.
REQ-017 SHALL store all four data_in values as one frame in a 2-slot frame buffer (write pointer, read pointer, count 0..2) on the clock edge at which a qualifying edge is detected.
REQ-018 SHALL assert m_axis_tvalid in the cycle following the store when the buffer was empty and no frame was in transmission (latency 1 cycle).
REQ-019 SHALL control output with two states:
- IDLE: go to SEND when count > 0.
- SEND: beat index 0..3; advance only on tvalid && tready; after beat 3 handshakes, release the slot, then go to IDLE if count becomes 0, else stay in SEND with index 0 (no idle bubble).
REQ-020 SHALL drive, for beat k, tdata = sign-extended data_in k of the head frame, tuser = k, and tlast = 1 only for k = 3.
REQ-021 SHALL hold tdata, tuser and tlast stable while tvalid is high and tready is low, and SHALL never deassert tvalid before its handshake.
REQ-022 SHALL drop a qualifying edge that arrives with count = 2, setting overflow = 1 and incrementing overflow_count, which saturates at 0xFFFF.
REQ-023 SHALL accept, not drop, a qualifying edge with count = 2 when the beat-3 handshake occurs in the same cycle; count then stays 2.
REQ-024 SHALL complete any frame already buffered or in transmission when enable falls.
REQ-025 SHALL let the overflow flag and counter be cleared only by rst.

Reset
REQ-026 SHALL, on rst asserted, immediately set:
- m_axis_tvalid = 0, m_axis_tlast = 0, m_axis_tdata = 0, m_axis_tuser = 0;
- overflow = 0, overflow_count = 0;
- buffer count and pointers = 0, state IDLE, decimation counter 0, registered eoc 0.
REQ-027 SHALL discard any partial frame when rst is asserted mid-frame; after release, output restarts at beat 0 of the next qualifying frame.

Verification
REQ-028 Bench: decimation = 0, tready = 1, one eoc pulse with data 0x123, 0xFFF, 0x800, 0x001 -> four beats with tdata 0x0123, 0xFFFF, 0xF800, 0x0001, tuser 0..3, tlast on beat 4, tvalid rising 1 cycle after the edge.
REQ-029 Bench: decimation = 2, 9 eoc pulses -> exactly 3 frames output, from pulses 1, 4 and 7.
REQ-030 Bench: tready = 0, 3 eoc pulses -> frames 1-2 buffered, overflow = 1, overflow_count = 1; tready = 1 -> frames 1 and 2 output back-to-back with no idle cycle.
REQ-031 Bench: count = 2, qualifying edge coincident with beat-3 handshake -> frame accepted, overflow stays 0.
REQ-032 Bench: tready toggled randomly during a frame -> tdata, tuser and tlast stable while stalled, no beat lost or duplicated.
REQ-033 Bench: rst pulsed during beat 2 -> tvalid = 0 immediately, counters 0, next frame starts with tuser = 0.
